// File: rtl/cache_mux_types.sv
// Shared types and sizes for the physical-memory arbiter and its line adaptor.
package cache_mux_types;

  localparam int PMEM_LINE_W = 256;
  localparam int PMEM_BEAT_W = 64;
  localparam int PMEM_ADDR_W = 32;
  localparam int BEATS       = PMEM_LINE_W / PMEM_BEAT_W;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/p_cacheline_adaptor.sv
// Beat counter, read-line assembly and write-beat select for one line burst.
module p_cacheline_adaptor
  import cache_mux_types::*;
#(
  parameter int LINE_W = PMEM_LINE_W,
  parameter int BEAT_W = PMEM_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              mem_resp,
  input  logic [BEAT_W-1:0] mem_burst_i,
  input  logic [LINE_W-1:0] wline,
  output logic [LINE_W-1:0] line_nxt,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_beat
);

  localparam int NB = LINE_W / BEAT_W;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  logic [KW-1:0]     k_q, k_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              step;

  assign step = active & mem_resp;

  always_comb begin
    k_d    = k_q;
    line_d = line_q;
    if (step) begin
      k_d = k_q + 1'b1;
      line_d[int'(k_q)*BEAT_W +: BEAT_W] = mem_burst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      line_q <= '0;
    end else begin
      k_q    <= k_d;
      line_q <= line_d;
    end
  end

  // line_nxt already holds the beat landing this cycle
  assign line_nxt  = line_d;
  assign beat_o    = wline[int'(k_q)*BEAT_W +: BEAT_W];
  assign last_beat = step && (k_q == KW'(NB - 1));

endmodule

// File: rtl/p_mem_arbiter.sv
// I/D cache line arbiter onto one bursting main-memory port.
// P_MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of D-first priority.
module p_mem_arbiter
  import cache_mux_types::*;
#(
  parameter int LINE_W = PMEM_LINE_W,
  parameter int BEAT_W = PMEM_BEAT_W,
  parameter int ADDR_W = PMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BEAT_W-1:0] mem_burst_o,
  input  logic [BEAT_W-1:0] mem_burst_i,
  input  logic              mem_resp
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  arb_state_t        state_q, state_d;
  arb_grant_t        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic              d_req;
  logic              pick_d;
  logic              active;
  logic              last_beat;
  logic [LINE_W-1:0] line_nxt;
  logic [BEAT_W-1:0] beat_o;

  assign d_req = d_pmem_read | d_pmem_write;

`ifdef P_MEM_ARB_ROUND_ROBIN_EN
  arb_grant_t last_q, last_d;

  // last_q names the side served most recently
  assign pick_d = d_req && (!i_pmem_read || last_q == GRANT_I);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (d_req || i_pmem_read))
      last_d = pick_d ? GRANT_D : GRANT_I;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= GRANT_I;
    else     last_q <= last_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req || i_pmem_read) begin
          wdata_d = d_pmem_wdata;
          if (pick_d) begin
            grant_d = GRANT_D;
            addr_d  = d_pmem_address & LINE_MASK;
            state_d = d_pmem_write ? D_WR : D_RD;
          end else begin
            grant_d = GRANT_I;
            addr_d  = i_pmem_address & LINE_MASK;
            state_d = I_RD;
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (last_beat) begin
          state_d = DONE;
          if (state_q == I_RD) i_rdata_d = line_nxt;
          if (state_q == D_RD) d_rdata_d = line_nxt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= GRANT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign active = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);

  p_cacheline_adaptor #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_adaptor (
    .clk         (clk),
    .rst         (rst),
    .active      (active),
    .mem_resp    (mem_resp),
    .mem_burst_i (mem_burst_i),
    .wline       (wdata_q),
    .line_nxt    (line_nxt),
    .beat_o      (beat_o),
    .last_beat   (last_beat)
  );

  assign mem_read     = (state_q == I_RD) || (state_q == D_RD);
  assign mem_write    = (state_q == D_WR);
  assign mem_address  = active ? addr_q : '0;
  assign mem_burst_o  = mem_write ? beat_o : '0;
  assign i_pmem_resp  = (state_q == DONE) && (grant_q == GRANT_I);
  assign d_pmem_resp  = (state_q == DONE) && (grant_q == GRANT_D);
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_rdata = d_rdata_q;

endmodule
